// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding and PC constants.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP       = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer feeding the IF/ID register. Keeps one request
// outstanding to a variable-latency instruction memory, holds a fetched word
// while the pipeline stalls, and follows redirects at any point of a fetch.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  REQ   | issue a request for pc this cycle (suppressed by redirect)
//  WAIT  | request outstanding, response will be kept
//  HOLD  | fetched word in ibuf, presented on IF_Instruction until consumed
//  DROP  | request outstanding, response will be thrown away (redirected)
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PC,
   output logic        fetch_busy
);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  ibuf, ibuf_nxt;

   // Next-state, next-pc and instruction-buffer capture.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ibuf_nxt  = ibuf;
      case (state)
         ST_REQ: begin
            if (redirect) pc_nxt    = redirect_target;
            else          state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_ready) begin
               if (redirect) begin
                  pc_nxt    = redirect_target;
                  state_nxt = ST_REQ;
               end else begin
                  ibuf_nxt  = imem_rdata;
                  state_nxt = ST_HOLD;
               end
            end else if (redirect) begin
               pc_nxt    = redirect_target;
               state_nxt = ST_DROP;
            end
         end
         ST_HOLD: begin
            // Redirect outranks stall: the held instruction is on a dead path.
            if (redirect) begin
               pc_nxt    = redirect_target;
               state_nxt = ST_REQ;
            end else if (!stall) begin
               pc_nxt    = pc + PC_STEP;
               state_nxt = ST_REQ;
            end
         end
         ST_DROP: begin
            if (redirect)   pc_nxt    = redirect_target;
            if (imem_ready) state_nxt = ST_REQ;
         end
         default: state_nxt = ST_REQ;
      endcase
   end

   // State, PC and buffer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_REQ;
         pc    <= RESET_PC;
         ibuf  <= 32'h0000_0000;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ibuf  <= ibuf_nxt;
      end
   end

   // Request strobe is masked during reset since state already reads REQ.
   assign imem_req       = reset && (state == ST_REQ) && !redirect;
   assign imem_addr      = pc;
   assign IF_Instruction = (state == ST_HOLD) ? ibuf : NOP_INSTR;
   assign IF_PC          = pc;
   assign fetch_busy     = (state != ST_HOLD);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic against a flag-based behavioural model of the fetch flow.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PC;
   logic        fetch_busy;

   int checks = 0;
   int errors = 0;

   if_fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .IF_Instruction(IF_Instruction),
      .IF_PC(IF_PC), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a fetch is either idle (about to ask), outstanding
   // (possibly already doomed by a redirect), or delivered and waiting to be taken.
   logic        m_out, m_discard, m_valid;
   logic [31:0] m_pc, m_buf;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_out = 0; m_discard = 0; m_valid = 0; m_pc = 32'h0; m_buf = 32'h0;
      end else if (m_valid) begin
         if (redirect)    begin m_pc = redirect_target; m_valid = 0; end
         else if (!stall) begin m_pc = m_pc + 32'd4;    m_valid = 0; end
      end else if (!m_out) begin
         if (redirect) m_pc = redirect_target;
         else begin m_out = 1; m_discard = 0; end
      end else begin
         if (imem_ready) begin
            m_out = 0;
            if (!m_discard && !redirect) begin m_valid = 1; m_buf = imem_rdata; end
         end else if (redirect) m_discard = 1;
         if (redirect) m_pc = redirect_target;
      end
   end

   // Every-cycle comparison against the model, after inputs have settled.
   always @(negedge clk) begin
      #1;
      check("req",   {31'b0, imem_req}, {31'b0, reset && !m_out && !m_valid && !redirect});
      check("addr",  imem_addr, m_pc);
      check("pc",    IF_PC, m_pc);
      check("instr", IF_Instruction, m_valid ? m_buf : 32'h0);
      check("busy",  {31'b0, fetch_busy}, {31'b0, !m_valid});
   end

   task automatic drive(input logic st, input logic rd, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] dat);
      @(negedge clk);
      stall = st; redirect = rd; redirect_target = tgt; imem_ready = rdy; imem_rdata = dat;
      #2;
   endtask

   logic        mem_pend;
   int          mem_lat;
   logic [31:0] mem_data;
   logic        r_st, r_rd, r_rdy;
   logic [31:0] r_tgt, r_dat;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_req",   {31'b0, imem_req}, 32'd0);
      check("rst_instr", IF_Instruction, 32'h0);
      check("rst_busy",  {31'b0, fetch_busy}, 32'd1);

      // 1: first fetch after reset release
      @(negedge clk); reset = 1'b1; #2;
      check("t1_req", {31'b0, imem_req}, 32'd1);
      check("t1_addr", imem_addr, 32'h0);
      drive(0, 0, 0, 1, 32'h2008_0005);
      drive(0, 0, 0, 0, 0);
      check("t1_instr", IF_Instruction, 32'h2008_0005);
      check("t1_pc", IF_PC, 32'h0);
      check("t1_busy", {31'b0, fetch_busy}, 32'd0);
      drive(0, 0, 0, 0, 0);
      check("t1_next", imem_addr, 32'h4);
      check("t1_nreq", {31'b0, imem_req}, 32'd1);

      // 2: stall in HOLD
      drive(0, 0, 0, 1, 32'hDEAD_0001);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0);
         check("t2_instr", IF_Instruction, 32'hDEAD_0001);
         check("t2_pc", IF_PC, 32'h4);
         check("t2_req", {31'b0, imem_req}, 32'd0);
      end
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      check("t2_next", imem_addr, 32'h8);
      check("t2_nreq", {31'b0, imem_req}, 32'd1);

      // 3: redirect in WAIT, late response is dropped
      drive(0, 1, 32'h100, 0, 0);
      drive(0, 0, 0, 0, 0);
      check("t3_busy", {31'b0, fetch_busy}, 32'd1);
      drive(0, 0, 0, 1, 32'hBAD0_BAD0);
      check("t3_instr", IF_Instruction, 32'h0);
      drive(0, 0, 0, 0, 0);
      check("t3_addr", imem_addr, 32'h100);
      check("t3_req", {31'b0, imem_req}, 32'd1);

      // 4: redirect coincident with ready in WAIT
      drive(0, 1, 32'h200, 1, 32'hBAD1_BAD1);
      drive(0, 0, 0, 0, 0);
      check("t4_addr", imem_addr, 32'h200);
      check("t4_busy", {31'b0, fetch_busy}, 32'd1);

      // 5: redirect beats stall in HOLD
      drive(0, 0, 0, 1, 32'h1234_5678);
      drive(1, 1, 32'h300, 0, 0);
      check("t5_hold", IF_Instruction, 32'h1234_5678);
      drive(0, 0, 0, 0, 0);
      check("t5_addr", imem_addr, 32'h300);
      check("t5_busy", {31'b0, fetch_busy}, 32'd1);

      // 6: PC wrap, then async reset while waiting
      drive(0, 1, 32'hFFFF_FFFC, 1, 32'hBAD2_BAD2);
      drive(0, 0, 0, 0, 0);
      check("t6_top", imem_addr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 1, 32'hCAFE_F00D);
      drive(0, 0, 0, 0, 0);
      check("t6_pc", IF_PC, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0);
      check("t6_wrap", imem_addr, 32'h0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 32'h0BAD_C0DE);
      drive(0, 0, 0, 0, 0);
      check("t6_held", IF_Instruction, 32'h0BAD_C0DE);
      check("t6_pc4", IF_PC, 32'h0);
      reset = 1'b0; #1;
      check("t6_rinstr", IF_Instruction, 32'h0);
      check("t6_rpc", IF_PC, 32'h0);
      check("t6_rreq", {31'b0, imem_req}, 32'd0);
      check("t6_rbusy", {31'b0, fetch_busy}, 32'd1);
      drive(0, 0, 0, 0, 0);
      @(negedge clk); reset = 1'b1; stall = 0; redirect = 0; imem_ready = 0;
      #2;

      // Randomized traffic with a memory of 1..3 cycle latency.
      mem_pend = imem_req; mem_lat = $urandom_range(2, 0); mem_data = $urandom;
      for (int n = 0; n < 4000; n++) begin
         r_st  = ($urandom_range(2, 0) == 0);
         r_rd  = ($urandom_range(5, 0) == 0);
         r_tgt = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFC : {$urandom_range(255, 0), 2'b00};
         r_rdy = 0; r_dat = $urandom;
         if (mem_pend) begin
            if (mem_lat == 0) begin r_rdy = 1; r_dat = mem_data; end
            else mem_lat--;
         end else if ($urandom_range(7, 0) == 0) r_rdy = 1;
         drive(r_st, r_rd, r_tgt, r_rdy, r_dat);
         if (r_rdy) mem_pend = 0;
         if (imem_req) begin
            mem_pend = 1; mem_lat = $urandom_range(2, 0); mem_data = $urandom;
         end
      end

      @(negedge clk); #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
